// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and write-back all finish in one clock.
// Instruction and data memories are internal byte arrays; the only ports are clock and reset.

module rv32i_mem #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o
);
    logic [7:0]           mem [0:2**ADDR_BITS-1];
    logic [ADDR_BITS-1:0] byte_addr [4];

    // Each byte lane computes its own address so misaligned words wrap at the top.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign byte_addr[k]       = addr_i + ADDR_BITS'(k);
        assign rdata_o[8*k +: 8] = mem[byte_addr[k]];
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (be_i[k]) mem[byte_addr[k]] <= wdata_i[8*k +: 8];
    end
endmodule

module rv32i_regfile #(
    parameter int N  = 32,
    parameter int M  = 32,
    parameter int RB = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RB-1:0] ra1_i,
    input  logic [RB-1:0] ra2_i,
    input  logic [RB-1:0] wa_i,
    input  logic          we_i,
    input  logic [N-1:0]  wd_i,
    output logic [N-1:0]  rd1_o,
    output logic [N-1:0]  rd2_o
);
    logic [N-1:0] registers [0:M-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < M; i++) registers[i] <= '0;
        end else if (we_i && (wa_i != '0)) begin
            registers[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : registers[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : registers[ra2_i];
endmodule

module rv32i_core #(
    parameter int ADDR_BITS = 10,
    parameter int N         = 32,
    parameter int M         = 32
) (
    input logic clk,
    input logic rst
);
    localparam int RB = $clog2(M);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    logic [N-1:0] pc_q, pc_d, pc_plus4;
    logic [31:0]  instr, dmem_rdata;
    logic [6:0]   opcode;
    logic [2:0]   f3;
    logic [N-1:0] rs1_v, rs2_v, wb_d, alu_b, alu_y, ls_imm;
    logic [N-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [4:0]   shamt;
    logic         rf_we, br_take, alt;
    logic [3:0]   dmem_be;

    rv32i_mem #(.ADDR_BITS(ADDR_BITS)) instr_mem (
        .clk(clk), .addr_i(pc_q[ADDR_BITS-1:0]), .be_i(4'b0), .wdata_i(32'b0), .rdata_o(instr)
    );

    rv32i_mem #(.ADDR_BITS(ADDR_BITS)) data_mem (
        .clk(clk), .addr_i(rs1_v[ADDR_BITS-1:0] + ls_imm[ADDR_BITS-1:0]),
        .be_i(dmem_be), .wdata_i(rs2_v), .rdata_o(dmem_rdata)
    );

    rv32i_regfile #(.N(N), .M(M)) regs_file (
        .clk(clk), .rst(rst), .ra1_i(instr[15 +: RB]), .ra2_i(instr[20 +: RB]),
        .wa_i(instr[7 +: RB]), .we_i(rf_we), .wd_i(wb_d), .rd1_o(rs1_v), .rd2_o(rs2_v)
    );

    assign opcode   = instr[6:0];
    assign f3       = instr[14:12];
    assign pc_plus4 = pc_q + 32'd4;
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u    = {instr[31:12], 12'b0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign ls_imm   = (opcode == OP_ST) ? imm_s : imm_i;

    // instr[30] selects SUB/SRA for register ops, but only SRAI among immediates.
    always_comb begin
        alu_b = (opcode == OP_REG) ? rs2_v : imm_i;
        alt   = instr[30] && ((opcode == OP_REG) || (f3 == 3'b101));
        shamt = alu_b[4:0];
        case (f3)
            3'b000:  alu_y = alt ? rs1_v - alu_b : rs1_v + alu_b;
            3'b001:  alu_y = rs1_v << shamt;
            3'b010:  alu_y = {{(N-1){1'b0}}, $signed(rs1_v) < $signed(alu_b)};
            3'b011:  alu_y = {{(N-1){1'b0}}, rs1_v < alu_b};
            3'b100:  alu_y = rs1_v ^ alu_b;
            3'b101:  alu_y = alt ? N'($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
            3'b110:  alu_y = rs1_v | alu_b;
            default: alu_y = rs1_v & alu_b;
        endcase
    end

    always_comb begin
        case (f3)
            3'b000:  br_take = rs1_v == rs2_v;
            3'b001:  br_take = rs1_v != rs2_v;
            3'b100:  br_take = $signed(rs1_v) < $signed(rs2_v);
            3'b101:  br_take = $signed(rs1_v) >= $signed(rs2_v);
            3'b110:  br_take = rs1_v < rs2_v;
            3'b111:  br_take = rs1_v >= rs2_v;
            default: br_take = 1'b0;
        endcase
    end

    always_comb begin
        pc_d    = pc_plus4;
        rf_we   = 1'b0;
        wb_d    = alu_y;
        dmem_be = 4'b0000;
        case (opcode)
            OP_LUI:   begin rf_we = 1'b1; wb_d = imm_u; end
            OP_AUIPC: begin rf_we = 1'b1; wb_d = pc_q + imm_u; end
            OP_JAL:   begin rf_we = 1'b1; wb_d = pc_plus4; pc_d = pc_q + imm_j; end
            OP_JALR:  begin
                rf_we = 1'b1;
                wb_d  = pc_plus4;
                pc_d  = (rs1_v + imm_i) & {{(N-1){1'b1}}, 1'b0};
            end
            OP_BR:    if (br_take) pc_d = pc_q + imm_b;
            OP_LD: begin
                rf_we = 1'b1;
                case (f3)
                    3'b000:  wb_d = {{24{dmem_rdata[7]}}, dmem_rdata[7:0]};
                    3'b001:  wb_d = {{16{dmem_rdata[15]}}, dmem_rdata[15:0]};
                    3'b010:  wb_d = dmem_rdata;
                    3'b100:  wb_d = {24'b0, dmem_rdata[7:0]};
                    3'b101:  wb_d = {16'b0, dmem_rdata[15:0]};
                    default: rf_we = 1'b0;
                endcase
            end
            OP_ST: begin
                case (f3)
                    3'b000:  dmem_be = 4'b0001;
                    3'b001:  dmem_be = 4'b0011;
                    3'b010:  dmem_be = 4'b1111;
                    default: dmem_be = 4'b0000;
                endcase
            end
            OP_IMM, OP_REG: rf_we = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= '0;
        else      pc_q <= pc_d;
    end
endmodule

// File: tb/tb_rv32i_core.sv
// Bench for rv32i_core: table-driven ALU vectors plus hand-written programs, checked via a scoreboard queue.

module tb_rv32i_core;
    logic clk = 1'b0;
    logic rst = 1'b1;

    rv32i_core dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    typedef enum {P_REG, P_PC, P_DMEM} probe_e;
    typedef struct {
        string        nm;
        probe_e       kind;
        int           idx;
        logic [31:0]  exp;
    } exp_t;
    typedef struct {
        string        nm;
        logic [31:0]  instr;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  exp;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] enc_i(int imm, int rs1, logic [2:0] f3, int rd, logic [6:0] op);
        logic [31:0] im;
        im = imm;
        return {im[11:0], 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, int rs2, int rs1, logic [2:0] f3, int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, logic [2:0] f3);
        logic [31:0] im;
        im = imm;
        return {im[11:5], 5'(rs2), 5'(rs1), f3, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, logic [2:0] f3);
        logic [31:0] im;
        im = imm;
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(logic [19:0] imm20, int rd, logic [6:0] op);
        return {imm20, 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] im;
        im = imm;
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return enc_i(imm, rs1, 3'h0, rd, 7'h13);
    endfunction
    function automatic logic [31:0] lui_of(int rd, logic [31:0] v);
        logic [31:0] h;
        h = v + 32'h800;
        return enc_u(h[31:12], rd, 7'h37);
    endfunction
    function automatic logic [31:0] addi_lo(int rd, logic [31:0] v);
        return enc_i(int'(v[11:0]), rd, 3'h0, rd, 7'h13);
    endfunction

    task automatic put(int addr, logic [31:0] w);
        for (int k = 0; k < 4; k++) dut.instr_mem.mem[(addr + k) % 1024] = w[8*k +: 8];
    endtask
    task automatic clear_dmem();
        for (int i = 0; i < 1024; i++) dut.data_mem.mem[i] = 8'h00;
    endtask
    // Hold the core in reset and wipe the program; data memory is cleared only on request.
    task automatic begin_test(bit wipe_data);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) dut.instr_mem.mem[i] = 8'h00;
        if (wipe_data) clear_dmem();
    endtask
    task automatic go(int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic run(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_v(string nm, probe_e k, int idx, logic [31:0] e);
        exp_t t;
        t.nm = nm; t.kind = k; t.idx = idx; t.exp = e;
        sb_q.push_back(t);
    endtask
    function automatic logic [31:0] probe(probe_e k, int idx);
        case (k)
            P_REG:   return dut.regs_file.registers[idx];
            P_PC:    return dut.pc_q;
            default: return {24'b0, dut.data_mem.mem[idx]};
        endcase
    endfunction
    task automatic drain();
        exp_t e;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = probe(e.kind, e.idx);
            n_cmp++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.nm, act, e.exp);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vt[$];
        clear_dmem();
        #1 rst = 1'b0;
        #1;
        expect_v("rst_pc", P_PC, 0, 32'h0);
        expect_v("rst_x1", P_REG, 1, 32'h0);
        expect_v("rst_x31", P_REG, 31, 32'h0);
        drain();

        vt.push_back('{"ADD",   enc_r(7'h00, 2, 1, 3'h0, 3), 32'd5,        32'hFFFFFFFD, 32'd2});
        vt.push_back('{"SUB",   enc_r(7'h20, 2, 1, 3'h0, 3), 32'd5,        32'hFFFFFFFD, 32'd8});
        vt.push_back('{"SLL",   enc_r(7'h00, 2, 1, 3'h1, 3), 32'd1,        32'd33,       32'd2});
        vt.push_back('{"SLT",   enc_r(7'h00, 2, 1, 3'h2, 3), 32'hFFFFFFFF, 32'd1,        32'd1});
        vt.push_back('{"SLTU",  enc_r(7'h00, 2, 1, 3'h3, 3), 32'hFFFFFFFF, 32'd1,        32'd0});
        vt.push_back('{"XOR",   enc_r(7'h00, 2, 1, 3'h4, 3), 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00});
        vt.push_back('{"SRL",   enc_r(7'h00, 2, 1, 3'h5, 3), 32'h80000000, 32'd4,        32'h08000000});
        vt.push_back('{"SRA",   enc_r(7'h20, 2, 1, 3'h5, 3), 32'h80000000, 32'd4,        32'hF8000000});
        vt.push_back('{"OR",    enc_r(7'h00, 2, 1, 3'h6, 3), 32'h12340000, 32'h00005678, 32'h12345678});
        vt.push_back('{"AND",   enc_r(7'h00, 2, 1, 3'h7, 3), 32'hFFFF0000, 32'h12345678, 32'h12340000});
        vt.push_back('{"ADDI",  enc_i(1,     1, 3'h0, 3, 7'h13), 32'h7FFFFFFF, 32'd0, 32'h80000000});
        vt.push_back('{"SLTI",  enc_i(-4,    1, 3'h2, 3, 7'h13), 32'hFFFFFFFB, 32'd0, 32'd1});
        vt.push_back('{"SLTIU", enc_i(-1,    1, 3'h3, 3, 7'h13), 32'd5,        32'd0, 32'd1});
        vt.push_back('{"XORI",  enc_i(-1,    1, 3'h4, 3, 7'h13), 32'h0F0F0F0F, 32'd0, 32'hF0F0F0F0});
        vt.push_back('{"ORI",   enc_i(12'h678, 1, 3'h6, 3, 7'h13), 32'h12345000, 32'd0, 32'h12345678});
        vt.push_back('{"ANDI",  enc_i(12'h0FF, 1, 3'h7, 3, 7'h13), 32'h12345678, 32'd0, 32'h00000078});
        vt.push_back('{"SLLI",  enc_i(31,    1, 3'h1, 3, 7'h13), 32'd1,        32'd0, 32'h80000000});
        vt.push_back('{"SRLI",  enc_i(31,    1, 3'h5, 3, 7'h13), 32'h80000000, 32'd0, 32'd1});
        vt.push_back('{"SRAI",  enc_i(12'h41F, 1, 3'h5, 3, 7'h13), 32'h80000000, 32'd0, 32'hFFFFFFFF});
        vt.push_back('{"LUI",   enc_u(20'hABCDE, 3, 7'h37),  32'd0, 32'd0, 32'hABCDE000});
        vt.push_back('{"AUIPC", enc_u(20'h00001, 3, 7'h17),  32'd0, 32'd0, 32'h00001010});

        foreach (vt[i]) begin
            begin_test(1'b0);
            put(0,  lui_of(1, vt[i].a));
            put(4,  addi_lo(1, vt[i].a));
            put(8,  lui_of(2, vt[i].b));
            put(12, addi_lo(2, vt[i].b));
            put(16, vt[i].instr);
            expect_v(vt[i].nm, P_REG, 3, vt[i].exp);
            go(5);
            drain();
        end

        begin_test(1'b1);
        put(0, addi(1, 0, 5));
        put(4, addi(2, 0, -3));
        put(8, enc_r(7'h00, 2, 1, 3'h0, 3));
        put(12, enc_r(7'h20, 2, 1, 3'h0, 4));
        expect_v("seq_x1", P_REG, 1, 32'd5);
        expect_v("seq_x2", P_REG, 2, 32'hFFFFFFFD);
        expect_v("seq_x3", P_REG, 3, 32'd2);
        expect_v("seq_x4", P_REG, 4, 32'd8);
        go(4);
        drain();

        begin_test(1'b1);
        put(0,  addi(1, 0, 12'h123));
        put(4,  enc_s(8, 1, 0, 3'h2));
        put(8,  enc_i(8, 0, 3'h0, 5, 7'h03));
        put(12, enc_i(9, 0, 3'h4, 6, 7'h03));
        put(16, enc_i(8, 0, 3'h2, 7, 7'h03));
        expect_v("sw_m8", P_DMEM, 8, 32'h23);
        expect_v("sw_m9", P_DMEM, 9, 32'h01);
        expect_v("lb_x5", P_REG, 5, 32'h23);
        expect_v("lbu_x6", P_REG, 6, 32'h01);
        expect_v("lw_x7", P_REG, 7, 32'h123);
        go(5);
        drain();

        begin_test(1'b1);
        put(0,  addi(1, 0, -1));
        put(4,  enc_s(0, 1, 0, 3'h0));
        put(8,  enc_i(0, 0, 3'h0, 2, 7'h03));
        put(12, enc_i(0, 0, 3'h4, 3, 7'h03));
        put(16, enc_s(2, 1, 0, 3'h1));
        put(20, enc_i(2, 0, 3'h1, 4, 7'h03));
        put(24, enc_i(2, 0, 3'h5, 5, 7'h03));
        expect_v("lb_sext", P_REG, 2, 32'hFFFFFFFF);
        expect_v("lbu_zext", P_REG, 3, 32'h000000FF);
        expect_v("lh_sext", P_REG, 4, 32'hFFFFFFFF);
        expect_v("lhu_zext", P_REG, 5, 32'h0000FFFF);
        expect_v("sb_only1", P_DMEM, 1, 32'h00);
        expect_v("sh_m3", P_DMEM, 3, 32'hFF);
        expect_v("sh_only2", P_DMEM, 4, 32'h00);
        go(7);
        drain();

        begin_test(1'b1);
        put(0,  lui_of(1, 32'h11223344));
        put(4,  addi_lo(1, 32'h11223344));
        put(8,  enc_s(1022, 1, 0, 3'h2));
        put(12, enc_i(1022, 0, 3'h2, 2, 7'h03));
        expect_v("wrap_m1022", P_DMEM, 1022, 32'h44);
        expect_v("wrap_m1023", P_DMEM, 1023, 32'h33);
        expect_v("wrap_m0", P_DMEM, 0, 32'h22);
        expect_v("wrap_m1", P_DMEM, 1, 32'h11);
        expect_v("wrap_lw", P_REG, 2, 32'h11223344);
        go(4);
        drain();

        begin_test(1'b0);
        put(0, enc_b(8, 0, 0, 3'h0));
        put(4, addi(1, 0, 1));
        put(8, addi(2, 0, 2));
        expect_v("beq_pc", P_PC, 0, 32'd8);
        go(1);
        drain();
        expect_v("beq_skip_x1", P_REG, 1, 32'd0);
        expect_v("beq_tgt_x2", P_REG, 2, 32'd2);
        run(1);
        drain();

        begin_test(1'b0);
        put(0, enc_b(8, 0, 0, 3'h1));
        expect_v("bne_pc", P_PC, 0, 32'd4);
        go(1);
        drain();

        begin_test(1'b0);
        put(0,  addi(1, 0, -1));
        put(4,  enc_b(8, 0, 1, 3'h4));
        put(12, enc_b(8, 0, 1, 3'h6));
        put(16, enc_b(-16, 0, 1, 3'h7));
        expect_v("blt_pc", P_PC, 0, 32'd12);
        go(2);
        drain();
        expect_v("bltu_pc", P_PC, 0, 32'd16);
        run(1);
        drain();
        expect_v("bgeu_back_pc", P_PC, 0, 32'd0);
        run(1);
        drain();

        begin_test(1'b0);
        put(0,  addi(0, 0, 7));
        put(4,  enc_j(12, 1));
        put(16, enc_i(1, 1, 3'h0, 2, 7'h67));
        expect_v("x0_zero", P_REG, 0, 32'd0);
        expect_v("x0_pc", P_PC, 0, 32'd4);
        go(1);
        drain();
        expect_v("jal_pc", P_PC, 0, 32'd16);
        expect_v("jal_x1", P_REG, 1, 32'd8);
        run(1);
        drain();
        expect_v("jalr_pc", P_PC, 0, 32'd8);
        expect_v("jalr_x2", P_REG, 2, 32'd20);
        run(1);
        drain();

        begin_test(1'b0);
        put(0,    enc_j(1020, 0));
        put(1020, addi(1, 0, 9));
        expect_v("fwrap_pc0", P_PC, 0, 32'd1020);
        go(1);
        drain();
        expect_v("fwrap_pc1", P_PC, 0, 32'd1024);
        expect_v("fwrap_x1", P_REG, 1, 32'd9);
        run(1);
        drain();
        expect_v("fwrap_pc2", P_PC, 0, 32'd2044);
        run(1);
        drain();

        begin_test(1'b1);
        put(0, addi(1, 1, 1));
        put(4, enc_s(16, 1, 0, 3'h2));
        put(8, enc_j(-8, 0));
        expect_v("loop_x1", P_REG, 1, 32'd3);
        expect_v("loop_pc", P_PC, 0, 32'd4);
        expect_v("loop_m16", P_DMEM, 16, 32'd2);
        go(7);
        drain();
        #2 rst = 1'b0;
        #1;
        expect_v("arst_pc", P_PC, 0, 32'd0);
        expect_v("arst_x1", P_REG, 1, 32'd0);
        expect_v("arst_m16", P_DMEM, 16, 32'd2);
        drain();
        expect_v("hold_pc", P_PC, 0, 32'd0);
        expect_v("hold_x1", P_REG, 1, 32'd0);
        run(1);
        drain();
        expect_v("restart_x1", P_REG, 1, 32'd1);
        expect_v("restart_pc", P_PC, 0, 32'd4);
        go(1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
